// File: rtl/fcu_pkg.sv
// rtl/fcu_pkg.sv - opcodes, FSM states and target selects for flow_control_unit
package fcu_pkg;

    localparam logic [4:0] OP_NOP    = 5'b00000;
    localparam logic [4:0] OP_JMP    = 5'b00001;
    localparam logic [4:0] OP_JMPC   = 5'b00101;
    localparam logic [4:0] OP_GTP    = 5'b01000;
    localparam logic [4:0] OP_JMPI   = 5'b01001;
    localparam logic [4:0] OP_JMPFI  = 5'b01010;
    localparam logic [4:0] OP_JMPBI  = 5'b01011;
    localparam logic [4:0] OP_JMPCI  = 5'b01101;
    localparam logic [4:0] OP_JMPCFI = 5'b01110;
    localparam logic [4:0] OP_JMPCBI = 5'b01111;
    localparam logic [4:0] OP_CALL   = 5'b10000;
    localparam logic [4:0] OP_CALLI  = 5'b10001;
    localparam logic [4:0] OP_RET    = 5'b10010;
    localparam logic [4:0] OP_WAIT   = 5'b10011;
    localparam logic [4:0] OP_HALT   = 5'b11000;
    localparam logic [4:0] OP_SYS    = 5'b11110;
    localparam logic [4:0] OP_SYSI   = 5'b11111;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        HALT
    } fcu_state_e;

    typedef enum logic [2:0] {
        ABS_REG,
        ABS_IMM,
        FWD,
        BACK,
        HERE,
        RAS
    } fcu_tgt_e;

endpackage

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - return-address stack; FCU_RAS_OVF_TRAP_EN selects trap-on-full vs circular overwrite
module return_addr_stack #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [PC_W-1:0]          push_data,
    output logic [PC_W-1:0]          pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     push_blocked
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign rd_ptr    = wr_ptr - PTR_W'(1);
    assign pop_data  = mem[rd_ptr];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign overflow  = push & full;
    assign underflow = pop & empty;

`ifdef FCU_RAS_OVF_TRAP_EN
    assign push_blocked = push & full;
`else
    assign push_blocked = 1'b0;
`endif

    assign do_push = push & ~push_blocked;
    assign do_pop  = pop & ~empty;

    // Storage write; with a full circular stack the write lands on the oldest slot
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy; count saturates at DEPTH when overwriting
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (do_pop) begin
            wr_ptr <= rd_ptr;
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/flow_control_unit.sv
// rtl/flow_control_unit.sv - control-flow decode, target mux, RUN/WAIT/HALT FSM; FCU_RAS_OVF_TRAP_EN enables overflow trap
module flow_control_unit
    import fcu_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int DATA_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_valid,
    input  logic                         enb,
    input  logic [DATA_W-1:0]            instr,
    input  logic [DATA_W-1:0]            f_reg,
    input  logic [DATA_W-1:0]            t_reg,
    input  logic [23:0]                  imm,
    input  logic [PC_W-1:0]              pc,
    input  logic                         wake,
    input  logic                         err_clr,
    output logic                         redirect_valid,
    output logic [PC_W-1:0]              redirect_pc,
    output logic                         stall,
    output logic                         halted,
    output logic                         sys_valid,
    output logic [23:0]                  sys_code,
    output logic                         kernel_valid,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf,
    output logic                         trap_valid
);

    fcu_state_e       state;
    fcu_state_e       state_next;
    fcu_tgt_e         tgt_sel;
    logic [4:0]       opcode;
    logic             accept;
    logic             cond_ok;
    logic             do_redirect;
    logic             do_sys;
    logic             do_kernel;
    logic             go_wait;
    logic             go_halt;
    logic [23:0]      sys_next;
    logic [PC_W-1:0]  imm_ext;
    logic [PC_W-1:0]  target;
    logic             ras_push;
    logic             ras_pop;
    logic [PC_W-1:0]  ras_pop_data;
    logic             ras_empty;
    logic             ras_overflow;
    logic             ras_underflow;
    logic             ras_push_blocked;
    logic             unused_bits;

    assign opcode      = instr[28:24];
    assign accept      = instr_valid & enb & (state == RUN);
    assign cond_ok     = (t_reg != '0);
    assign imm_ext     = PC_W'(imm[15:0]);
    assign unused_bits = ^{instr, f_reg};

    return_addr_stack #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk          (clk),
        .rst          (rst),
        .push         (ras_push),
        .pop          (ras_pop),
        .push_data    (pc + PC_W'(1)),
        .pop_data     (ras_pop_data),
        .count        (ras_count),
        .empty        (ras_empty),
        .overflow     (ras_overflow),
        .underflow    (ras_underflow),
        .push_blocked (ras_push_blocked)
    );

    // Opcode decode; nothing fires unless the instruction is accepted
    always_comb begin
        tgt_sel     = HERE;
        do_redirect = 1'b0;
        do_sys      = 1'b0;
        do_kernel   = 1'b0;
        go_wait     = 1'b0;
        go_halt     = 1'b0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        sys_next    = imm;
        if (accept) begin
            case (opcode)
                OP_JMP:    begin tgt_sel = ABS_REG; do_redirect = 1'b1;    end
                OP_JMPI:   begin tgt_sel = ABS_IMM; do_redirect = 1'b1;    end
                OP_JMPFI:  begin tgt_sel = FWD;     do_redirect = 1'b1;    end
                OP_JMPBI:  begin tgt_sel = BACK;    do_redirect = 1'b1;    end
                OP_JMPC:   begin tgt_sel = ABS_REG; do_redirect = cond_ok; end
                OP_JMPCI:  begin tgt_sel = ABS_IMM; do_redirect = cond_ok; end
                OP_JMPCFI: begin tgt_sel = FWD;     do_redirect = cond_ok; end
                OP_JMPCBI: begin tgt_sel = BACK;    do_redirect = cond_ok; end
                OP_CALL: begin
                    tgt_sel     = ABS_REG;
                    ras_push    = 1'b1;
                    do_redirect = ~ras_push_blocked;
                end
                OP_CALLI: begin
                    tgt_sel     = ABS_IMM;
                    ras_push    = 1'b1;
                    do_redirect = ~ras_push_blocked;
                end
                OP_RET: begin
                    tgt_sel     = RAS;
                    ras_pop     = 1'b1;
                    do_redirect = ~ras_empty;
                end
                OP_WAIT: go_wait = 1'b1;
                OP_HALT: begin
                    tgt_sel     = HERE;
                    do_redirect = 1'b1;
                    go_halt     = 1'b1;
                end
                OP_SYS:  do_sys = 1'b1;
                OP_SYSI: begin
                    do_sys   = 1'b1;
                    sys_next = f_reg[23:0];
                end
                OP_GTP:  do_kernel = 1'b1;
                default: ;
            endcase
        end
    end

    // Redirect target mux, all arithmetic wraps at PC_W bits
    always_comb begin
        target = pc;
        case (tgt_sel)
            ABS_REG: target = f_reg[PC_W-1:0];
            ABS_IMM: target = imm_ext;
            FWD:     target = pc + imm_ext;
            BACK:    target = pc - imm_ext;
            RAS:     target = ras_pop_data;
            default: target = pc;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; wake only counts once already in WAIT
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (go_halt) begin
                    state_next = HALT;
                end else if (go_wait) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wake) begin
                    state_next = RUN;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // Registered outputs: one-cycle pulses, held redirect/sys values, sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stall          <= 1'b0;
            halted         <= 1'b0;
            sys_valid      <= 1'b0;
            sys_code       <= '0;
            kernel_valid   <= 1'b0;
            ras_ovf        <= 1'b0;
            ras_unf        <= 1'b0;
            trap_valid     <= 1'b0;
        end else begin
            redirect_valid <= do_redirect;
            if (do_redirect) begin
                redirect_pc <= target;
            end
            stall     <= (state_next != RUN);
            halted    <= (state_next == HALT);
            sys_valid <= do_sys;
            if (do_sys) begin
                sys_code <= sys_next;
            end
            kernel_valid <= do_kernel;
            trap_valid   <= ras_push_blocked;
            if (ras_overflow) begin
                ras_ovf <= 1'b1;
            end else if (err_clr) begin
                ras_ovf <= 1'b0;
            end
            if (ras_underflow) begin
                ras_unf <= 1'b1;
            end else if (err_clr) begin
                ras_unf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flow_control_unit.sv
// tb/tb_flow_control_unit.sv - randomized and directed bench for flow_control_unit with a queue-based model
module tb_flow_control_unit;

    localparam int PC_W      = 16;
    localparam int DATA_W    = 32;
    localparam int RAS_DEPTH = 8;
    localparam int CW        = $clog2(RAS_DEPTH) + 1;

    localparam logic [4:0] JMP = 5'h01, JMPC = 5'h05, GTP = 5'h08, JMPI = 5'h09, JMPFI = 5'h0A;
    localparam logic [4:0] JMPBI = 5'h0B, JMPCI = 5'h0D, JMPCFI = 5'h0E, JMPCBI = 5'h0F;
    localparam logic [4:0] CALL = 5'h10, CALLI = 5'h11, RET = 5'h12, WAITOP = 5'h13;
    localparam logic [4:0] HALTOP = 5'h18, SYS = 5'h1E, SYSI = 5'h1F;

    logic              clk = 1'b0;
    logic              rst, instr_valid, enb, wake, err_clr;
    logic [DATA_W-1:0] instr, f_reg, t_reg;
    logic [23:0]       imm;
    logic [PC_W-1:0]   pc;
    logic              redirect_valid, stall, halted, sys_valid, kernel_valid;
    logic              ras_ovf, ras_unf, trap_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic [23:0]       sys_code;
    logic [CW-1:0]     ras_count;

    int checks = 0;
    int errors = 0;

    // reference model: 0=run 1=wait 2=halt, stack as a queue (back = newest)
    int          m_state;
    int          ras_q[$];
    logic        e_rv, e_sv, e_kv, e_tv, e_ovf, e_unf;
    logic [15:0] e_rpc;
    logic [23:0] e_code;

    always #5 clk = ~clk;

    flow_control_unit #(
        .PC_W(PC_W), .DATA_W(DATA_W), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .enb(enb), .instr(instr),
        .f_reg(f_reg), .t_reg(t_reg), .imm(imm), .pc(pc), .wake(wake), .err_clr(err_clr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .halted(halted), .sys_valid(sys_valid), .sys_code(sys_code),
        .kernel_valid(kernel_valid), .ras_count(ras_count), .ras_ovf(ras_ovf),
        .ras_unf(ras_unf), .trap_valid(trap_valid)
    );

    task automatic clear_in();
        rst = 0; instr_valid = 0; enb = 0; wake = 0; err_clr = 0;
        instr = '0; f_reg = '0; t_reg = '0; imm = '0; pc = '0;
    endtask

    task automatic drive(input logic [4:0] op, input logic [15:0] p, input logic [23:0] im,
                         input logic [31:0] f, input logic [31:0] t);
        logic [2:0]  hi;
        logic [23:0] lo;
        hi = 3'($urandom);
        lo = 24'($urandom);
        instr_valid = 1; enb = 1;
        instr = {hi, op, lo}; pc = p; imm = im; f_reg = f; t_reg = t;
    endtask

    task automatic redirect_to(input int t);
        e_rv  = 1;
        e_rpc = t[15:0];
    endtask

    // applies the current inputs to the model, then clocks the DUT and settles
    task automatic tick();
        logic [4:0] op;
        bit         acc;
        int         tgt;
        bit         is_jump;
        bit         is_cond;
        op = instr[28:24];
        e_rv = 0; e_sv = 0; e_kv = 0; e_tv = 0;
        tgt = 0; is_jump = 0; is_cond = 0;
        if (rst) begin
            m_state = 0; ras_q.delete();
            e_rpc = 0; e_code = 0; e_ovf = 0; e_unf = 0;
        end else begin
            acc = instr_valid && enb && (m_state == 0);
            if (err_clr) begin e_ovf = 0; e_unf = 0; end
            if (m_state == 1 && wake) m_state = 0;
            if (acc) begin
                case (op)
                    JMP, JMPC:     begin is_jump = 1; tgt = int'(f_reg[15:0]); end
                    JMPI, JMPCI:   begin is_jump = 1; tgt = int'(imm[15:0]); end
                    JMPFI, JMPCFI: begin is_jump = 1; tgt = (int'(pc) + int'(imm[15:0])) % 65536; end
                    JMPBI, JMPCBI: begin is_jump = 1; tgt = (int'(pc) - int'(imm[15:0]) + 65536) % 65536; end
                    default: ;
                endcase
                is_cond = (op == JMPC || op == JMPCI || op == JMPCFI || op == JMPCBI);
                if (is_jump && (!is_cond || t_reg != 0)) redirect_to(tgt);
                if (op == CALL || op == CALLI) begin
                    tgt = (op == CALL) ? int'(f_reg[15:0]) : int'(imm[15:0]);
                    if (ras_q.size() == RAS_DEPTH) begin
                        e_ovf = 1;
`ifdef FCU_RAS_OVF_TRAP_EN
                        e_tv = 1;
`else
                        void'(ras_q.pop_front());
                        ras_q.push_back((int'(pc) + 1) % 65536);
                        redirect_to(tgt);
`endif
                    end else begin
                        ras_q.push_back((int'(pc) + 1) % 65536);
                        redirect_to(tgt);
                    end
                end
                if (op == RET) begin
                    if (ras_q.size() == 0) e_unf = 1;
                    else redirect_to(ras_q.pop_back());
                end
                if (op == WAITOP) m_state = 1;
                if (op == HALTOP) begin redirect_to(int'(pc)); m_state = 2; end
                if (op == SYS)  begin e_sv = 1; e_code = imm; end
                if (op == SYSI) begin e_sv = 1; e_code = f_reg[23:0]; end
                if (op == GTP)  e_kv = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_in(); rst = 1; tick(); tick(); clear_in();
        checks++;
        if ({redirect_valid, redirect_pc, stall, halted, sys_valid, sys_code} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got rv=%0b rpc=%h st=%0b h=%0b sv=%0b code=%h expected all 0",
                     redirect_valid, redirect_pc, stall, halted, sys_valid, sys_code);
        end
        checks++;
        if ({kernel_valid, ras_count, ras_ovf, ras_unf, trap_valid} !== '0) begin
            errors++;
            $display("FAIL reset_ras got kv=%0b cnt=%0d ovf=%0b unf=%0b tv=%0b expected all 0",
                     kernel_valid, ras_count, ras_ovf, ras_unf, trap_valid);
        end
    endtask

    task automatic test_jumps();
        drive(JMPFI, 16'h0010, 24'h000005, 0, 0); tick(); clear_in();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0015) begin
            errors++; $display("FAIL jmpfi got rv=%0b pc=%h expected 1/0015", redirect_valid, redirect_pc);
        end
        tick();
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++; $display("FAIL pulse_width got rv=%0b expected 0", redirect_valid);
        end
        drive(JMPBI, 16'h0002, 24'h000004, 0, 0); tick(); clear_in();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'hFFFE) begin
            errors++; $display("FAIL jmpbi_wrap got rv=%0b pc=%h expected 1/fffe", redirect_valid, redirect_pc);
        end
        drive(JMPCI, 16'h0030, 24'h000123, 0, 32'h2); tick(); clear_in();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0123) begin
            errors++; $display("FAIL jmpci_taken got rv=%0b pc=%h expected 1/0123", redirect_valid, redirect_pc);
        end
        drive(JMPCI, 16'h0030, 24'h000456, 0, 32'h0); tick(); clear_in();
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 16'h0123) begin
            errors++; $display("FAIL jmpci_not_taken got rv=%0b pc=%h expected 0/0123", redirect_valid, redirect_pc);
        end
        drive(JMP, 16'h0030, 24'h0, 32'h0000_ABCD, 0); enb = 0; tick(); clear_in();
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++; $display("FAIL enb_low got rv=%0b expected 0", redirect_valid);
        end
        drive(SYSI, 16'h0, 24'h111111, 32'h55AB_CDEF, 0); tick(); clear_in();
        checks++;
        if (sys_valid !== 1'b1 || sys_code !== 24'hABCDEF) begin
            errors++; $display("FAIL sysi got sv=%0b code=%h expected 1/abcdef", sys_valid, sys_code);
        end
    endtask

    task automatic test_call_ret();
        clear_in(); rst = 1; tick(); clear_in();
        drive(CALLI, 16'h0040, 24'h000100, 0, 0); tick(); clear_in();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0100 || ras_count !== CW'(1)) begin
            errors++; $display("FAIL call got rv=%0b pc=%h cnt=%0d expected 1/0100/1", redirect_valid, redirect_pc, ras_count);
        end
        drive(RET, 16'h0100, 24'h0, 0, 0); tick(); clear_in();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0041 || ras_count !== CW'(0)) begin
            errors++; $display("FAIL ret got rv=%0b pc=%h cnt=%0d expected 1/0041/0", redirect_valid, redirect_pc, ras_count);
        end
    endtask

    task automatic test_overflow();
        int first;
        clear_in(); rst = 1; tick(); clear_in();
        for (int i = 0; i <= RAS_DEPTH; i++) begin
            drive(CALLI, 16'h1000 + 16'(i * 4), 24'h000200 + 24'(i), 0, 0); tick();
        end
        clear_in();
`ifdef FCU_RAS_OVF_TRAP_EN
        checks++;
        if (trap_valid !== 1'b1 || ras_ovf !== 1'b1 || redirect_valid !== 1'b0 || ras_count !== CW'(RAS_DEPTH)) begin
            errors++; $display("FAIL ovf_trap got tv=%0b ovf=%0b rv=%0b cnt=%0d expected 1/1/0/%0d",
                               trap_valid, ras_ovf, redirect_valid, ras_count, RAS_DEPTH);
        end
        first = RAS_DEPTH - 1;
`else
        checks++;
        if (trap_valid !== 1'b0 || ras_ovf !== 1'b1 || redirect_valid !== 1'b1 ||
            redirect_pc !== 16'h0200 + 16'(RAS_DEPTH) || ras_count !== CW'(RAS_DEPTH)) begin
            errors++; $display("FAIL ovf_wrap got tv=%0b ovf=%0b rv=%0b pc=%h cnt=%0d expected 0/1/1/%h/%0d",
                               trap_valid, ras_ovf, redirect_valid, redirect_pc, ras_count,
                               16'h0200 + 16'(RAS_DEPTH), RAS_DEPTH);
        end
        first = RAS_DEPTH;
`endif
        for (int k = 0; k < RAS_DEPTH; k++) begin
            drive(RET, 16'h0, 24'h0, 0, 0); tick(); clear_in();
            checks++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 16'h1000 + 16'((first - k) * 4) + 16'h1) begin
                errors++; $display("FAIL ovf_ret%0d got rv=%0b pc=%h expected 1/%h", k, redirect_valid,
                                   redirect_pc, 16'h1000 + 16'((first - k) * 4) + 16'h1);
            end
        end
        checks++;
        if (ras_count !== CW'(0)) begin
            errors++; $display("FAIL ovf_drain got cnt=%0d expected 0", ras_count);
        end
    endtask

    task automatic test_underflow();
        clear_in(); rst = 1; tick(); clear_in();
        drive(RET, 16'h0, 24'h0, 0, 0); tick(); clear_in();
        checks++;
        if (redirect_valid !== 1'b0 || ras_unf !== 1'b1 || ras_count !== CW'(0)) begin
            errors++; $display("FAIL unf got rv=%0b unf=%0b cnt=%0d expected 0/1/0", redirect_valid, ras_unf, ras_count);
        end
        err_clr = 1; tick(); clear_in();
        checks++;
        if (ras_unf !== 1'b0) begin
            errors++; $display("FAIL unf_clr got unf=%0b expected 0", ras_unf);
        end
        drive(RET, 16'h0, 24'h0, 0, 0); err_clr = 1; tick(); clear_in();
        checks++;
        if (ras_unf !== 1'b1) begin
            errors++; $display("FAIL unf_wins got unf=%0b expected 1", ras_unf);
        end
    endtask

    task automatic test_wait();
        int high;
        clear_in(); rst = 1; tick(); clear_in();
        drive(WAITOP, 16'h0, 24'h0, 0, 0); tick(); clear_in();
        high = 0;
        for (int c = 1; c <= 6; c++) begin
            if (stall === 1'b1) high++;
            if (c == 3) wake = 1;
            drive(JMPI, 16'h0, 24'h000777, 0, 0); if (c > 3) instr_valid = 0;
            tick(); clear_in();
        end
        checks++;
        if (high !== 3 || stall !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL wait got high=%0d stall=%0b rv=%0b expected 3/0/0", high, stall, redirect_valid);
        end
        drive(WAITOP, 16'h0, 24'h0, 0, 0); wake = 1; tick(); clear_in(); tick();
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL wake_coincident got stall=%0b expected 1", stall);
        end
        wake = 1; tick(); clear_in();
    endtask

    task automatic test_halt();
        drive(HALTOP, 16'h0777, 24'h0, 0, 0); tick(); clear_in();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 16'h0777 || halted !== 1'b1 || stall !== 1'b1) begin
            errors++; $display("FAIL halt got rv=%0b pc=%h h=%0b st=%0b expected 1/0777/1/1",
                               redirect_valid, redirect_pc, halted, stall);
        end
        for (int c = 0; c < 3; c++) begin
            drive(JMPI, 16'h0, 24'h000123, 0, 0); wake = 1; tick(); clear_in();
        end
        checks++;
        if (redirect_valid !== 1'b0 || halted !== 1'b1 || redirect_pc !== 16'h0777) begin
            errors++; $display("FAIL halt_hold got rv=%0b h=%0b pc=%h expected 0/1/0777", redirect_valid, halted, redirect_pc);
        end
        rst = 1; tick(); clear_in(); tick();
        checks++;
        if (halted !== 1'b0 || stall !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++; $display("FAIL halt_rst got h=%0b st=%0b rv=%0b expected 0/0/0", halted, stall, redirect_valid);
        end
    endtask

    task automatic test_random();
        logic [4:0] op;
        int         pick;
        for (int n = 0; n < 3000; n++) begin
            pick = $urandom_range(0, 9);
            if (pick < 2) op = CALLI;
            else if (pick < 3) op = CALL;
            else if (pick < 5) op = RET;
            else op = 5'($urandom);
            drive(op, 16'($urandom), 24'($urandom), $urandom, ($urandom_range(0, 2) == 0) ? 0 : $urandom);
            instr_valid = ($urandom_range(0, 3) != 0);
            enb         = ($urandom_range(0, 7) != 0);
            wake        = ($urandom_range(0, 3) == 0);
            err_clr     = ($urandom_range(0, 15) == 0);
            rst         = ($urandom_range(0, 63) == 0);
            tick();
            checks++;
            if ({redirect_valid, redirect_pc, sys_valid, sys_code, kernel_valid, trap_valid} !==
                {e_rv, e_rpc, e_sv, e_code, e_kv, e_tv}) begin
                errors++;
                $display("FAIL rand_pulse@%0d got rv=%0b pc=%h sv=%0b code=%h kv=%0b tv=%0b expected %0b %h %0b %h %0b %0b",
                         n, redirect_valid, redirect_pc, sys_valid, sys_code, kernel_valid, trap_valid,
                         e_rv, e_rpc, e_sv, e_code, e_kv, e_tv);
            end
            checks++;
            if ({stall, halted, ras_count, ras_ovf, ras_unf} !==
                {(m_state != 0), (m_state == 2), CW'(ras_q.size()), e_ovf, e_unf}) begin
                errors++;
                $display("FAIL rand_state@%0d got st=%0b h=%0b cnt=%0d ovf=%0b unf=%0b expected %0b %0b %0d %0b %0b",
                         n, stall, halted, ras_count, ras_ovf, ras_unf,
                         (m_state != 0), (m_state == 2), ras_q.size(), e_ovf, e_unf);
            end
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        m_state = 0;
        e_rv = 0; e_sv = 0; e_kv = 0; e_tv = 0; e_ovf = 0; e_unf = 0; e_rpc = 0; e_code = 0;
        @(negedge clk);
        test_reset();
        test_jumps();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_wait();
        test_halt();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flow_control_unit.md
# flow_control_unit

Registered, parametrised successor to the combinational program decoder. Decodes control-flow opcodes (instr bits [28:24]) and computes redirect targets. Adds an internal return-address stack (RAS) for CALL/RET, a RUN/WAIT/HALT state machine that drives the fetch stall, and sticky stack-error flags. Sits between the instruction register and the PC/fetch stage.

## Interface
- PC_W, 16, program-counter and target width
- DATA_W, 32, register and instruction width
- RAS_DEPTH, 8, return-stack entries (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- instr_valid  in  1  instr holds a decodable instruction this cycle
- enb  in  1  control-flow decode enable
- instr  in  DATA_W  current instruction; opcode = instr[28:24]
- f_reg  in  DATA_W  first-operand register value
- t_reg  in  DATA_W  condition register value
- imm  in  24  immediate field
- pc  in  PC_W  PC of the current instruction
- wake  in  1  event pulse that releases WAIT
- err_clr  in  1  clears the sticky error flags
- redirect_valid  out  1  one-cycle pulse: load redirect_pc
- redirect_pc  out  PC_W  redirect target
- stall  out  1  fetch must hold
- halted  out  1  core is in HALT
- sys_valid / sys_code  out  1 / 24  syscall pulse and code
- kernel_valid  out  1  GTP pulse
- ras_count  out  $clog2(RAS_DEPTH)+1  live entries
- ras_ovf, ras_unf  out  1  sticky overflow / underflow
- trap_valid  out  1  overflow trap pulse (macro-dependent)

## Operation
- Accept = instr_valid & enb & state==RUN. Non-accepted cycles have no side effects.
- Targets: abs_reg = f_reg[PC_W-1:0]; abs_imm = imm[15:0] zero-extended; fwd = pc + imm[15:0]; back = pc − imm[15:0]; all arithmetic modulo 2^PC_W.
- JMP 00001 → abs_reg; JMPi 01001 → abs_imm; JMPfi 01010 → fwd; JMPbi 01011 → back; HALT 11000 → pc, then enter HALT.
- Conditional opcodes JMPC 00101, JMPCi 01101, JMPCfi 01110, JMPCbi 01111 use the same targets. They redirect only if t_reg != 0; this applies uniformly to all four.
- CALL 10000 (abs_reg) / CALLi 10001 (abs_imm): push pc+1, then redirect.
- RET 10010: pop and redirect to the popped value.
- RET on an empty stack: no redirect, ras_unf ← 1, count stays 0.
- WAIT 10011: enter WAIT; no redirect.
- SYS 11110 → sys_code = imm. SYSi 11111 → sys_code = f_reg[23:0]. sys_valid pulses in both cases.
- GTP 01000: kernel_valid pulse.
- NOP, PUSH, POP, GSA, SWITCH and undefined opcodes: no action.
- State machine:
  - RUN → WAIT on WAIT; RUN → HALT on HALT.
  - WAIT → RUN on the cycle after wake=1. A wake coincident with WAIT acceptance is ignored.
  - HALT exits only on rst.
- stall = (state != RUN). halted = (state == HALT).
- err_clr clears ras_ovf/ras_unf. If an error occurs in the same cycle as err_clr, the error wins.

## Timing
- All outputs are registered. Reset value is 0 for every output, including redirect_pc and ras_count; state resets to RUN and the RAS is emptied.
- Redirect, sys, kernel and trap pulses appear 1 cycle after acceptance and last exactly 1 cycle.
- stall rises 1 cycle after WAIT/HALT acceptance, together with HALT's redirect pulse.
- RAS update is visible in ras_count 1 cycle after acceptance.
- Back-to-back accepted CALL/RET are supported every cycle.
- RET immediately after CALL returns the just-pushed value.
- rst mid-WAIT or mid-HALT returns to RUN with no pulse on the following cycle.

## Configuration
- FCU_RAS_OVF_TRAP_EN defined: CALL with a full RAS performs no push and no redirect. It pulses trap_valid and sets ras_ovf.
- FCU_RAS_OVF_TRAP_EN undefined: CALL with a full RAS overwrites the oldest entry (circular stack). It sets ras_ovf and redirects normally; count stays RAS_DEPTH and trap_valid is tied 0.

## Structure
- Package fcu_pkg holds:
  - opcode localparams (5-bit)
  - state enum {RUN, WAIT, HALT}
  - target-select enum {ABS_REG, ABS_IMM, FWD, BACK, HERE, RAS}
- Sub-module return_addr_stack holds storage, pointer, count, push/pop/full/empty and the overflow policy.
- Top level holds decode, the target mux and the FSM.

## Test plan
- pc=0x0010, JMPfi imm=0x0005 → next cycle redirect_valid=1, redirect_pc=0x0015. JMPbi at pc=0x0002, imm=0x0004 → 0xFFFE (wrap).
- JMPCi with t_reg=0x2 → redirect taken (t_reg != 0). Same with t_reg=0 → no pulse.
- CALLi 0x0100 at pc=0x0040, then RET → redirects 0x0100 then 0x0041; ras_count goes 1 then 0.
- RAS_DEPTH+1 CALLs:
  - macro defined: last CALL gives trap_valid=1, ras_ovf=1, no redirect.
  - macro undefined: redirect issues, count=RAS_DEPTH, and RAS_DEPTH RETs return the newest entries.
- RET on empty → ras_unf=1, no redirect; err_clr → ras_unf=0 next cycle.
- WAIT then wake 3 cycles later → stall high for 3 cycles, then low. HALT → halted=1 until rst, and further instructions are ignored.
